pipe_alu_acc: RTL and testbench

Parametrised two-stage pipelined ALU with valid/ready handshakes on input and output, and an accumulator mode. It generalises the team's 8-bit combinational ALU in several ways:
- width is set by NBITS;
- adds arithmetic shift right, carry/borrow and zero flags;
- in accumulate mode, the previous result replaces in0.
Used in datapath tiles where operands arrive as a stream and downstream logic may stall.

---
 rtl/pipe_alu_acc.sv | 119 +++++++++++
 tb/tb_pipe_alu_acc.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_alu_acc.sv
// Two-stage pipelined ALU with valid/ready handshakes and an accumulator.
// Stage A registers operands; stage B registers the result and flags.
module pipe_alu_acc #(
    parameter int unsigned NBITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    input  logic [2:0]       op,
    input  logic             acc_en,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out,
    output logic             cout,
    output logic             zero
);

    localparam int unsigned SHBITS = $clog2(NBITS);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd2;
    localparam logic [2:0] OP_SHR = 3'd3;
    localparam logic [2:0] OP_LT  = 3'd4;
    localparam logic [2:0] OP_EQ  = 3'd5;
    localparam logic [2:0] OP_GT  = 3'd6;
    localparam logic [2:0] OP_SRA = 3'd7;

    typedef struct packed {
        logic [NBITS-1:0] in0;
        logic [NBITS-1:0] in1;
        logic [2:0]       op;
        logic             acc_en;
    } stage_a_t;

    logic             a_val;
    stage_a_t         a_q;
    logic [NBITS-1:0] acc;

    logic             in_xfer;
    logic             a_adv;
    logic             out_xfer;

    logic [NBITS-1:0] opa;
    logic [SHBITS-1:0] sh;
    logic [NBITS:0]   sum;
    logic [NBITS-1:0] res_c;
    logic             cout_c;

    // in_rdy looks through a stalled pipe straight to out_rdy
    assign in_rdy   = !a_val || !out_val || out_rdy;
    assign in_xfer  = in_val && in_rdy;
    assign a_adv    = a_val && (!out_val || out_rdy);
    assign out_xfer = out_val && out_rdy;

    // Result from the stage-A registers; acc replaces in0 in accumulate mode
    always_comb begin
        opa    = a_q.acc_en ? acc : a_q.in0;
        sh     = a_q.in1[SHBITS-1:0];
        sum    = {1'b0, opa} + {1'b0, a_q.in1};
        res_c  = '0;
        cout_c = 1'b0;
        case (a_q.op)
            OP_ADD: begin
                res_c  = sum[NBITS-1:0];
                cout_c = sum[NBITS];
            end
            OP_SUB: begin
                res_c  = opa - a_q.in1;
                cout_c = (opa < a_q.in1);
            end
            OP_SHL: res_c = opa << sh;
            OP_SHR: res_c = opa >> sh;
            OP_LT:  res_c = {{(NBITS-1){1'b0}}, (opa < a_q.in1)};
            OP_EQ:  res_c = {{(NBITS-1){1'b0}}, (opa == a_q.in1)};
            OP_GT:  res_c = {{(NBITS-1){1'b0}}, (opa > a_q.in1)};
            OP_SRA: res_c = $unsigned($signed(opa) >>> sh);
        endcase
    end

    // Stage A: operand register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_val <= 1'b0;
            a_q   <= '0;
        end else if (in_xfer) begin
            a_val      <= 1'b1;
            a_q.in0    <= in0;
            a_q.in1    <= in1;
            a_q.op     <= op;
            a_q.acc_en <= acc_en;
        end else if (a_adv) begin
            a_val <= 1'b0;
        end
    end

    // Stage B: result register and accumulator, both written on advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_val <= 1'b0;
            out     <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
            acc     <= '0;
        end else if (a_adv) begin
            out_val <= 1'b1;
            out     <= res_c;
            cout    <= cout_c;
            zero    <= (res_c == '0);
            acc     <= res_c;
        end else if (out_xfer) begin
            out_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_alu_acc.sv
// Bench for pipe_alu_acc: in-order scoreboard fed by an arithmetic model,
// directed literal checks, and a randomized handshake phase.
module tb_pipe_alu_acc;

    logic       clk;
    logic       reset_n;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [2:0] op;
    logic       acc_en;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out;
    logic       cout;
    logic       zero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [9:0] mq[$];     // expected {cout, zero, out} per in-flight transaction
    int         macc = 0;
    int         dval[$];
    int         dcyc[$];

    pipe_alu_acc #(.NBITS(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_val(in_val), .in_rdy(in_rdy),
        .in0(in0), .in1(in1), .op(op), .acc_en(acc_en),
        .out_val(out_val), .out_rdy(out_rdy),
        .out(out), .cout(cout), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Plain-arithmetic reference for one 8-bit operation
    function automatic logic [9:0] model(input int o, input int a, input int b);
        int r;
        int sa;
        int sh;
        bit c;
        c  = 1'b0;
        sh = b % 8;
        sa = (a >= 128) ? a - 256 : a;
        case (o)
            0: begin r = a + b; c = (r > 255); r = r % 256; end
            1: begin r = (a - b + 256) % 256; c = (a < b); end
            2: r = (a << sh) % 256;
            3: r = a >> sh;
            4: r = (a < b) ? 1 : 0;
            5: r = (a == b) ? 1 : 0;
            6: r = (a > b) ? 1 : 0;
            default: r = (sa >>> sh) & 255;
        endcase
        return {c, (r == 0), 8'(r)};
    endfunction

    // Scoreboard: sampled at negedge, when handshake signals are settled
    always @(negedge clk) begin
        logic [9:0] e;
        int a;
        if (!reset_n) begin
            chk("reset_outputs", {28'd0, out_val, cout, zero, (out != 8'd0)}, 32'd0);
            mq.delete();
            macc = 0;
        end else begin
            chk("in_rdy", {31'd0, in_rdy}, {31'd0, (mq.size() < 2) || out_rdy});
            if (out_val) begin
                if (mq.size() == 0)
                    chk("spurious_out_val", 32'd1, 32'd0);
                else
                    chk("result", {22'd0, cout, zero, out}, {22'd0, mq[0]});
                if (out_rdy && mq.size() > 0) begin
                    void'(mq.pop_front());
                    dval.push_back(int'(out));
                    dcyc.push_back(cyc);
                end
            end
            if (in_val && in_rdy) begin
                a = acc_en ? macc : int'(in0);
                e = model(int'(op), a, int'(in1));
                macc = int'(e[7:0]);
                mq.push_back(e);
            end
        end
    end

    // One transaction, unstalled; result checked two cycles after it is offered
    task automatic run_one(input string name, input logic [2:0] o, input logic [7:0] a,
                           input logic [7:0] b, input logic ae, input logic [7:0] eo,
                           input logic ec, input logic ez);
        @(posedge clk); #1;
        out_rdy = 1'b1; in_val = 1'b1; op = o; in0 = a; in1 = b; acc_en = ae;
        @(posedge clk); #1;
        in_val = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk(name, {21'd0, out_val, cout, zero, out}, {21'd0, 1'b1, ec, ez, eo});
    endtask

    initial begin
        int idx;
        reset_n = 1'b1; in_val = 1'b0; in0 = '0; in1 = '0; op = '0; acc_en = 1'b0;
        out_rdy = 1'b0;

        // Reset held for three cycles with in_val asserted
        #1 reset_n = 1'b0;
        in_val = 1'b1; in0 = 8'h11; in1 = 8'h22;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1; in_val = 1'b0;
        @(negedge clk);
        chk("rdy_after_reset", {31'd0, in_rdy}, 32'd1);
        chk("idle_after_reset", {31'd0, out_val}, 32'd0);

        // Arithmetic, shifts, compares
        run_one("add_carry", 3'd0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0);
        run_one("sub_borrow", 3'd1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0);
        run_one("sub_zero", 3'd1, 8'h07, 8'h07, 1'b0, 8'h00, 1'b0, 1'b1);
        run_one("shl_mask", 3'd2, 8'h81, 8'h09, 1'b0, 8'h02, 1'b0, 1'b0);
        run_one("shr", 3'd3, 8'h80, 8'h03, 1'b0, 8'h10, 1'b0, 1'b0);
        run_one("sra", 3'd7, 8'h80, 8'h03, 1'b0, 8'hF0, 1'b0, 1'b0);
        run_one("lt", 3'd4, 8'd3, 8'd200, 1'b0, 8'h01, 1'b0, 1'b0);
        run_one("gt", 3'd6, 8'd3, 8'd200, 1'b0, 8'h00, 1'b0, 1'b1);
        run_one("eq", 3'd5, 8'd9, 8'd9, 1'b0, 8'h01, 1'b0, 1'b0);

        // Accumulate chain on consecutive cycles: 8, 12, 10
        @(posedge clk); #1;
        out_rdy = 1'b1; in_val = 1'b1; op = 3'd0; in0 = 8'd5; in1 = 8'd3; acc_en = 1'b0;
        @(posedge clk); #1;
        op = 3'd0; in0 = 8'hAA; in1 = 8'd4; acc_en = 1'b1;
        @(posedge clk); #1;
        op = 3'd1; in0 = 8'h55; in1 = 8'd2; acc_en = 1'b1;
        @(negedge clk);
        chk("acc_1", {23'd0, out_val, out}, {23'd0, 1'b1, 8'd8});
        @(posedge clk); #1;
        in_val = 1'b0; acc_en = 1'b0;
        @(negedge clk);
        chk("acc_2", {23'd0, out_val, out}, {23'd0, 1'b1, 8'd12});
        @(negedge clk);
        chk("acc_3", {23'd0, out_val, out}, {23'd0, 1'b1, 8'd10});
        @(posedge clk); #1;

        // Backpressure: four transactions, out_rdy low
        out_rdy = 1'b0;
        idx = 0;
        repeat (6) begin
            @(posedge clk); #1;
            in_val = (idx < 4); op = 3'd0; acc_en = 1'b0;
            in0 = 8'(idx + 1); in1 = 8'(idx + 1);
            @(negedge clk);
            if (in_val && in_rdy) idx++;
        end
        chk("bp_accepted", idx, 32'd2);
        chk("bp_in_rdy_low", {31'd0, in_rdy}, 32'd0);
        chk("bp_out_held", {23'd0, out_val, out}, {23'd0, 1'b1, 8'd2});
        dval.delete(); dcyc.delete();
        for (int k = 0; k < 20 && idx < 4; k++) begin
            @(posedge clk); #1;
            out_rdy = 1'b1; in_val = 1'b1; op = 3'd0; acc_en = 1'b0;
            in0 = 8'(idx + 1); in1 = 8'(idx + 1);
            @(negedge clk);
            if (in_val && in_rdy) idx++;
        end
        @(posedge clk); #1;
        in_val = 1'b0;
        for (int k = 0; k < 20 && dval.size() < 4; k++) @(negedge clk);
        chk("bp_count", dval.size(), 32'd4);
        if (dval.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("bp_order", dval[i], 32'(2 * (i + 1)));
            for (int i = 0; i < 3; i++) chk("bp_back_to_back", dcyc[i + 1] - dcyc[i], 32'd1);
        end

        // Reset with both stages full, then accumulate from acc=0
        @(posedge clk); #1;
        out_rdy = 1'b0; in_val = 1'b1; op = 3'd0; in0 = 8'd50; in1 = 8'd60; acc_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 in_val = 1'b0;
        @(negedge clk);
        chk("full_before_reset", {30'd0, out_val, in_rdy}, {30'd0, 1'b1, 1'b0});
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {22'd0, out_val, cout, out}, 32'd0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        run_one("acc_after_reset", 3'd0, 8'd99, 8'd7, 1'b1, 8'd7, 1'b0, 1'b0);

        // Randomized traffic against the scoreboard
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            in_val  = ($urandom_range(3) != 0);
            out_rdy = ($urandom_range(2) != 0);
            op      = 3'($urandom_range(7));
            acc_en  = ($urandom_range(2) == 0);
            in0     = 8'($urandom);
            in1     = ($urandom_range(4) == 0) ? in0 : 8'($urandom);
        end
        @(posedge clk); #1;
        in_val = 1'b0; out_rdy = 1'b1;
        for (int k = 0; k < 20 && mq.size() > 0; k++) @(negedge clk);
        chk("drain_empty", mq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
